// File: rtl/xadc_axil_read_sniffer_if.sv
// Sample stream from the XADC read sniffer to the capture/register block.
// The master drives data and valid, and the slave drives ready.
interface xadc_axil_read_sniffer_if;
  logic [11:0] m_data;
  logic [15:0] m_seq;
  logic        m_valid;
  logic        m_ready;

  modport master (output m_data, output m_seq, output m_valid, input  m_ready);
  modport slave  (input  m_data, input  m_seq, input  m_valid, output m_ready);
endinterface

// File: rtl/xadc_axil_read_sniffer.sv
// Passive AXI4-Lite read monitor. It pairs AR and R beats in order and queues
// 12-bit XADC results from the configured channel register into a FWFT FIFO.
module xadc_axil_read_sniffer #(
  parameter int unsigned          ADDR_W     = 12,
  parameter logic [ADDR_W-1:0]    CH_ADDR    = 12'h20C,
  parameter logic [ADDR_W-1:0]    CH_MASK    = 12'hFFC,
  parameter int unsigned          TAG_DEPTH  = 4,
  parameter int unsigned          FIFO_DEPTH = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        enable,
  input  logic [ADDR_W-1:0]           mon_araddr,
  input  logic                        mon_arvalid,
  input  logic                        mon_arready,
  input  logic [31:0]                 mon_rdata,
  input  logic [1:0]                  mon_rresp,
  input  logic                        mon_rvalid,
  input  logic                        mon_rready,
  xadc_axil_read_sniffer_if.master    sample,
  output logic [15:0]                 drop_cnt,
  output logic [15:0]                 err_cnt,
  output logic                        proto_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned TAG_PW  = $clog2(TAG_DEPTH);
  localparam int unsigned TAG_CW  = TAG_PW + 1;
  localparam int unsigned FIFO_PW = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CW = FIFO_PW + 1;

  typedef struct packed {
    logic [11:0] data;
    logic [15:0] seq;
  } sample_t;

  // Tag FIFO: one match bit per outstanding read, in AR order
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [TAG_PW-1:0]    tag_wr;
  logic [TAG_PW-1:0]    tag_rd;
  logic [TAG_CW-1:0]    tag_cnt;

  sample_t              s_mem [FIFO_DEPTH];
  logic [FIFO_PW-1:0]   s_wr;
  logic [FIFO_PW-1:0]   s_rd;
  logic [15:0]          seq_cnt;

  logic                 ar_hs;
  logic                 r_hs;
  logic                 ar_match;
  logic                 tag_empty;
  logic                 tag_full;
  logic                 tag_pop;
  logic                 tag_push;
  logic                 proto_evt;
  logic                 cap_ok;
  logic                 cap_err;
  logic                 s_pop;
  logic                 s_full;
  logic                 s_push;
  logic                 s_drop;
  logic [FIFO_PW-1:0]   s_rd_nxt;
  logic [FIFO_CW-1:0]   lvl_nxt;
  sample_t              push_word;
  sample_t              head_nxt;
  logic                 unused_rdata;

  assign unused_rdata = ^{mon_rdata[31:16], mon_rdata[3:0]};

  // Handshake decode, tag bookkeeping and capture decisions
  always_comb begin
    ar_hs     = mon_arvalid & mon_arready;
    r_hs      = mon_rvalid & mon_rready;
    ar_match  = (mon_araddr & CH_MASK) == (CH_ADDR & CH_MASK);
    tag_empty = (tag_cnt == '0);
    tag_full  = (tag_cnt == TAG_CW'(TAG_DEPTH));
    tag_pop   = r_hs & ~tag_empty;
    // a simultaneous pop frees the slot, so a full tag FIFO can still accept
    tag_push  = ar_hs & (~tag_full | tag_pop);
    proto_evt = (r_hs & tag_empty) | (ar_hs & tag_full & ~tag_pop);

    cap_ok    = tag_pop & tag_mem[tag_rd] & enable & (mon_rresp == 2'b00);
    cap_err   = tag_pop & tag_mem[tag_rd] & enable & (mon_rresp != 2'b00);

    s_pop     = sample.m_valid & sample.m_ready;
    s_full    = (fifo_level == FIFO_CW'(FIFO_DEPTH));
    s_push    = cap_ok & (~s_full | s_pop);
    s_drop    = cap_ok & s_full & ~s_pop;

    push_word = '{data: mon_rdata[15:4], seq: seq_cnt};
    s_rd_nxt  = s_pop ? s_rd + FIFO_PW'(1) : s_rd;
    lvl_nxt   = fifo_level + FIFO_CW'(s_push) - FIFO_CW'(s_pop);
    // when the FIFO would be empty before this push, the new word bypasses to the head
    head_nxt  = ((fifo_level - FIFO_CW'(s_pop)) == '0) ? push_word : s_mem[s_rd_nxt];
  end

  // Storage arrays carry no reset; validity comes from the pointers
  always_ff @(posedge aclk) begin
    if (tag_push) tag_mem[tag_wr] <= ar_match;
    if (s_push)   s_mem[s_wr]     <= push_word;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      tag_wr         <= '0;
      tag_rd         <= '0;
      tag_cnt        <= '0;
      proto_err      <= 1'b0;
      seq_cnt        <= '0;
      err_cnt        <= '0;
      drop_cnt       <= '0;
      s_wr           <= '0;
      s_rd           <= '0;
      fifo_level     <= '0;
      sample.m_valid <= 1'b0;
      sample.m_data  <= '0;
      sample.m_seq   <= '0;
    end else begin
      if (tag_push) tag_wr <= tag_wr + TAG_PW'(1);
      if (tag_pop)  tag_rd <= tag_rd + TAG_PW'(1);
      tag_cnt   <= tag_cnt + TAG_CW'(tag_push) - TAG_CW'(tag_pop);
      proto_err <= proto_err | proto_evt;

      // sequence advances on every OKAY capture, dropped or not, so gaps are visible
      if (cap_ok) seq_cnt <= seq_cnt + 16'd1;
      if (cap_err && (err_cnt != 16'hFFFF))  err_cnt  <= err_cnt + 16'd1;
      if (s_drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;

      if (s_push) s_wr <= s_wr + FIFO_PW'(1);
      s_rd           <= s_rd_nxt;
      fifo_level     <= lvl_nxt;
      sample.m_valid <= (lvl_nxt != '0);
      if (lvl_nxt != '0) begin
        sample.m_data <= head_nxt.data;
        sample.m_seq  <= head_nxt.seq;
      end
    end
  end

endmodule
